pkt_loader: RTL and testbench

- Bus manager that drives the endpoint's peripheral bus from the host side. It loads one outbound message into the endpoint and launches it.
- Per command, it writes the packet start-address register for the message ID, streams N data words into the TX cache window, then writes the message ID to the TX send register.
- It sits between a host-side word stream and the endpoint bus port.

---
 rtl/chiplet_types_pkg.sv | 19 +
 rtl/bus_mgr_xfer.sv | 81 ++++++++
 rtl/pkt_loader.sv | 191 +++++++++++++++++++
 tb/tb_pkt_loader.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chiplet_types_pkg.sv
// Shared chiplet types: endpoint register map constants and the packet-loader
// state encoding, so the endpoint and its bus managers agree on one map.
package chiplet_types_pkg;

  // Endpoint peripheral-bus register map
  localparam logic [31:0] TX_SEND_ADDR        = 32'h0000_1004;
  localparam logic [31:0] TX_CACHE_START_ADDR = 32'h0000_2000;

  typedef enum logic [2:0] {
    StIdle,
    StSetAddr,
    StVerify,
    StWriteData,
    StSend,
    StDone,
    StErr
  } pkt_loader_state_e;

endpackage

// File: rtl/bus_mgr_xfer.sv
// Single-transfer holder for the endpoint bus manager port.
// A request presented while the peripheral stalls is latched and replayed
// unchanged until a non-stalled cycle, which completes the transfer.
// Ports:
//   clk, n_rst                 clock, asynchronous active-low reset
//   req_valid/wen/ren/addr/wdata  request from the owning FSM
//   bus_*                      manager-side bus outputs / peripheral status
//   complete                   transfer finishes this cycle
//   err                        completing transfer flagged bus_error
module bus_mgr_xfer (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        req_valid,
  input  logic        req_wen,
  input  logic        req_ren,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        bus_error,
  input  logic        bus_request_stall,
  output logic [31:0] bus_addr,
  output logic        bus_wen,
  output logic        bus_ren,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_strobe,
  output logic        complete,
  output logic        err
);

  logic        held_q;
  logic        wen_q;
  logic        ren_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        active;

  assign active = held_q | req_valid;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      held_q  <= 1'b0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (active && bus_request_stall) begin
      // Capture only on the first stalled cycle; later cycles replay it.
      if (!held_q) begin
        held_q  <= 1'b1;
        wen_q   <= req_wen;
        ren_q   <= req_ren;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end else begin
      held_q <= 1'b0;
    end
  end

  always_comb begin
    bus_addr  = '0;
    bus_wen   = 1'b0;
    bus_ren   = 1'b0;
    bus_wdata = '0;
    if (held_q) begin
      bus_addr  = addr_q;
      bus_wen   = wen_q;
      bus_ren   = ren_q;
      bus_wdata = wdata_q;
    end else if (req_valid) begin
      bus_addr  = req_addr;
      bus_wen   = req_wen;
      bus_ren   = req_ren;
      bus_wdata = req_wdata;
    end
  end

  assign bus_strobe = bus_wen ? 4'hF : 4'h0;
  assign complete   = active & ~bus_request_stall;
  assign err        = complete & bus_error;

endmodule

// File: rtl/pkt_loader.sv
// Packet loader: host-side bus manager that loads one outbound message into
// the endpoint and launches it. Per accepted command it writes the message's
// packet start-address register, streams num_words words into the TX cache
// window, then writes the message ID to the TX send register.
// Optional macro PKT_LOADER_READBACK_EN: read back the start-address register
// after writing it and fail the command on mismatch; when undefined bus_ren
// stays 0.
// Ports:
//   clk, n_rst                      clock, asynchronous active-low reset
//   cmd_valid/ready/msg_id/start_addr/num_words  command handshake
//   data_valid/ready/word           host word stream
//   bus_addr/wen/ren/wdata/strobe   manager bus request
//   bus_rdata/error/request_stall   peripheral response
//   done, error                     one-cycle completion / failure pulses
module pkt_loader #(
  parameter int unsigned NUM_MSGS            = 4,
  parameter int unsigned CACHE_NUM_WORDS     = 128,
  parameter logic [31:0] TX_SEND_ADDR        = chiplet_types_pkg::TX_SEND_ADDR,
  parameter logic [31:0] TX_CACHE_START_ADDR = chiplet_types_pkg::TX_CACHE_START_ADDR
) (
  input  logic                               clk,
  input  logic                               n_rst,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [$clog2(NUM_MSGS)-1:0]        cmd_msg_id,
  input  logic [$clog2(4*CACHE_NUM_WORDS)-1:0] cmd_start_addr,
  input  logic [$clog2(CACHE_NUM_WORDS):0]   cmd_num_words,
  input  logic                               data_valid,
  output logic                               data_ready,
  input  logic [31:0]                        data_word,
  output logic [31:0]                        bus_addr,
  output logic                               bus_wen,
  output logic                               bus_ren,
  output logic [31:0]                        bus_wdata,
  output logic [3:0]                         bus_strobe,
  input  logic [31:0]                        bus_rdata,
  input  logic                               bus_error,
  input  logic                               bus_request_stall,
  output logic                               done,
  output logic                               error
);

  import chiplet_types_pkg::*;

  localparam int unsigned ID_W = $clog2(NUM_MSGS);
  localparam int unsigned SA_W = $clog2(4 * CACHE_NUM_WORDS);
  localparam int unsigned NW_W = $clog2(CACHE_NUM_WORDS) + 1;

`ifdef PKT_LOADER_READBACK_EN
  localparam pkt_loader_state_e AfterSetAddr = StVerify;
`else
  localparam pkt_loader_state_e AfterSetAddr = StWriteData;
`endif

  pkt_loader_state_e state_q;
  logic [ID_W-1:0]   msg_q;
  logic [SA_W-1:0]   start_q;   // word aligned
  logic [NW_W-1:0]   nwords_q;
  logic [NW_W-1:0]   cnt_q;

  logic        reject;
  logic        req_valid;
  logic        req_wen;
  logic        req_ren;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        xfer_complete;
  logic        xfer_err;

  // Window bound in words; 32-bit sum so the check itself cannot wrap.
  assign reject = (32'(cmd_msg_id) >= NUM_MSGS) || (cmd_num_words == '0) ||
                  (32'(cmd_start_addr[SA_W-1:2]) + 32'(cmd_num_words) > CACHE_NUM_WORDS);

  always_comb begin
    req_valid = 1'b0;
    req_wen   = 1'b0;
    req_ren   = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    unique case (state_q)
      StSetAddr: begin
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_addr  = 32'(msg_q) << 2;
        req_wdata = 32'(start_q);
      end
`ifdef PKT_LOADER_READBACK_EN
      StVerify: begin
        req_valid = 1'b1;
        req_ren   = 1'b1;
        req_addr  = 32'(msg_q) << 2;
      end
`endif
      StWriteData: begin
        // Stream gaps simply leave the bus idle; cnt_q only moves on completion.
        req_valid = data_valid;
        req_wen   = data_valid;
        req_addr  = TX_CACHE_START_ADDR + 32'(start_q) + (32'(cnt_q) << 2);
        req_wdata = data_word;
      end
      StSend: begin
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_addr  = TX_SEND_ADDR;
        req_wdata = 32'(msg_q);
      end
      default: ;
    endcase
  end

  bus_mgr_xfer u_xfer (
    .clk               (clk),
    .n_rst             (n_rst),
    .req_valid         (req_valid),
    .req_wen           (req_wen),
    .req_ren           (req_ren),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .bus_error         (bus_error),
    .bus_request_stall (bus_request_stall),
    .bus_addr          (bus_addr),
    .bus_wen           (bus_wen),
    .bus_ren           (bus_ren),
    .bus_wdata         (bus_wdata),
    .bus_strobe        (bus_strobe),
    .complete          (xfer_complete),
    .err               (xfer_err)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= StIdle;
      msg_q    <= '0;
      start_q  <= '0;
      nwords_q <= '0;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            msg_q    <= cmd_msg_id;
            start_q  <= {cmd_start_addr[SA_W-1:2], 2'b00};
            nwords_q <= cmd_num_words;
            cnt_q    <= '0;
            state_q  <= reject ? StErr : StSetAddr;
          end
        end
        StSetAddr: begin
          if (xfer_complete) state_q <= xfer_err ? StErr : AfterSetAddr;
        end
`ifdef PKT_LOADER_READBACK_EN
        StVerify: begin
          if (xfer_complete) begin
            state_q <= (xfer_err || (bus_rdata[SA_W-1:0] != start_q)) ? StErr : StWriteData;
          end
        end
`endif
        StWriteData: begin
          if (xfer_complete) begin
            cnt_q <= cnt_q + 1'b1;
            if (xfer_err) begin
              state_q <= StErr;
            end else if (cnt_q == nwords_q - 1'b1) begin
              state_q <= StSend;
            end
          end
        end
        StSend: begin
          if (xfer_complete) state_q <= xfer_err ? StErr : StDone;
        end
        StDone:  state_q <= StIdle;
        StErr:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready  = (state_q == StIdle);
  assign data_ready = (state_q == StWriteData) & xfer_complete;
  assign done       = (state_q == StDone);
  assign error      = (state_q == StErr);

`ifdef PKT_LOADER_READBACK_EN
  logic unused_rdata_hi;
  assign unused_rdata_hi = ^bus_rdata[31:SA_W];
`else
  logic unused_rdata;
  assign unused_rdata = ^bus_rdata;
`endif

endmodule

// File: tb/tb_pkt_loader.sv
`timescale 1ns/1ps
module tb_pkt_loader;

  localparam int unsigned NUM_MSGS        = 4;
  localparam int unsigned CACHE_NUM_WORDS = 128;
  localparam int ID_W = 2;
  localparam int SA_W = 9;
  localparam int NW_W = 8;
`ifdef PKT_LOADER_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  logic            clk = 1'b0;
  logic            n_rst;
  logic            cmd_valid, cmd_valid3;
  logic            cmd_ready, cmd_ready3;
  logic [ID_W-1:0] cmd_msg_id;
  logic [SA_W-1:0] cmd_start_addr;
  logic [NW_W-1:0] cmd_num_words;
  logic            data_valid, data_ready, data_ready3;
  logic [31:0]     data_word;
  logic [31:0]     bus_addr, bus_wdata, bus_rdata, bus_addr3, bus_wdata3;
  logic            bus_wen, bus_ren, bus_wen3, bus_ren3;
  logic [3:0]      bus_strobe, bus_strobe3;
  logic            bus_error, bus_request_stall;
  logic            done, error, done3, error3;
  logic            err_on_send;

  always #5 clk = ~clk;

  pkt_loader dut (
    .clk(clk), .n_rst(n_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_msg_id(cmd_msg_id),
    .cmd_start_addr(cmd_start_addr), .cmd_num_words(cmd_num_words),
    .data_valid(data_valid), .data_ready(data_ready), .data_word(data_word),
    .bus_addr(bus_addr), .bus_wen(bus_wen), .bus_ren(bus_ren), .bus_wdata(bus_wdata),
    .bus_strobe(bus_strobe), .bus_rdata(bus_rdata), .bus_error(bus_error),
    .bus_request_stall(bus_request_stall), .done(done), .error(error)
  );

  // Three slots: with four, a 2-bit id cannot encode an out-of-range slot.
  pkt_loader #(.NUM_MSGS(3)) dut3 (
    .clk(clk), .n_rst(n_rst),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_msg_id(cmd_msg_id),
    .cmd_start_addr(cmd_start_addr), .cmd_num_words(cmd_num_words),
    .data_valid(data_valid), .data_ready(data_ready3), .data_word(data_word),
    .bus_addr(bus_addr3), .bus_wen(bus_wen3), .bus_ren(bus_ren3), .bus_wdata(bus_wdata3),
    .bus_strobe(bus_strobe3), .bus_rdata(bus_rdata), .bus_error(bus_error),
    .bus_request_stall(bus_request_stall), .done(done3), .error(error3)
  );

  // Peripheral model: start-address registers, TX cache, optional error on send
  logic [31:0] slot_reg [NUM_MSGS];
  logic [31:0] cache_mem [CACHE_NUM_WORDS];
  assign bus_error = err_on_send && bus_wen && (bus_addr == 32'h1004);
  assign bus_rdata = (bus_ren && bus_addr < 32'h10) ? slot_reg[bus_addr[3:2]] : 32'h0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit in_cache(input logic [31:0] a);
    return (a >= 32'h2000) && (a < 32'h2000 + 4 * CACHE_NUM_WORDS);
  endfunction

  // Expected write sequence (model) and observed writes (log)
  logic [31:0] exp_addr_q[$], exp_data_q[$];
  logic [31:0] obs_addr_q[$], obs_data_q[$];
  logic [31:0] words[$];
  int done_cnt = 0, err_cnt = 0, consumed = 0;

  task automatic model_load(input int msg, input int sa, input int n);
    int base;
    base = sa & ~3;
    exp_addr_q.push_back(32'(msg * 4));
    exp_data_q.push_back(32'(base));
    for (int i = 0; i < n; i++) begin
      exp_addr_q.push_back(32'(32'h2000 + base + 4 * i));
      exp_data_q.push_back(words[i]);
    end
    exp_addr_q.push_back(32'h1004);
    exp_data_q.push_back(32'(msg));
  endtask

  // Compare process
  initial begin
    logic        prev_hold;
    logic [31:0] prev_addr, prev_wdata, ea, ed;
    prev_hold = 1'b0;
    prev_addr = '0;
    prev_wdata = '0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        prev_hold = 1'b0;
      end else begin
        if (bus_wen || bus_ren) check("wen_ren_exclusive", {31'b0, bus_wen & bus_ren}, 32'h0);
        if (bus_wen) check("strobe", {28'b0, bus_strobe}, 32'hF);
        if (prev_hold) begin
          check("stall_hold_addr", bus_addr, prev_addr);
          check("stall_hold_wdata", bus_wdata, prev_wdata);
          check("stall_hold_req", {31'b0, bus_wen | bus_ren}, 32'h1);
        end
        if (bus_wen && in_cache(bus_addr)) begin
          check("cache_write_needs_valid", {31'b0, data_valid}, 32'h1);
          if (data_valid) check("cache_wdata_is_stream", bus_wdata, data_word);
        end
        check("data_ready_rule", {31'b0, data_ready},
              {31'b0, bus_wen && !bus_request_stall && in_cache(bus_addr)});
        if (bus_wen && !bus_request_stall) begin
          obs_addr_q.push_back(bus_addr);
          obs_data_q.push_back(bus_wdata);
          if (in_cache(bus_addr)) cache_mem[(bus_addr - 32'h2000) >> 2] = bus_wdata;
          if (bus_addr < 32'h10) slot_reg[bus_addr[3:2]] = bus_wdata;
          if (exp_addr_q.size() == 0) begin
            check("unexpected_write", {31'b0, bus_wen}, 32'h0);
          end else begin
            ea = exp_addr_q.pop_front();
            ed = exp_data_q.pop_front();
            check("write_addr", bus_addr, ea);
            check("write_data", bus_wdata, ed);
          end
        end
        if (data_ready) consumed++;
        if (done) done_cnt++;
        if (error) err_cnt++;
        prev_hold = (bus_wen || bus_ren) && bus_request_stall;
        prev_addr = bus_addr;
        prev_wdata = bus_wdata;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  bit stream_abort = 1'b0;

  // Presents words[] in order; optional idle gap before index gap_at
  task automatic stream(input int gap_at, input int gap_len);
    bit got;
    int guard;
    for (int i = 0; i < words.size(); i++) begin
      if (i == gap_at) begin
        data_valid = 1'b0;
        repeat (gap_len) tick();
      end
      data_valid = 1'b1;
      data_word = words[i];
      got = 1'b0;
      guard = 0;
      while (!got && !stream_abort && guard < 100) begin
        @(negedge clk);
        guard++;
        if (data_ready) got = 1'b1;
      end
      if (stream_abort) break;
      if (!got) begin
        check("stream_word_timeout", {31'b0, data_ready}, 32'h1);
        break;
      end
      tick();
    end
    data_valid = 1'b0;
  endtask

  // Returns just after the accept edge
  task automatic issue(input int msg, input int sa, input int n);
    @(negedge clk);
    check("cmd_ready_before_cmd", {31'b0, cmd_ready}, 32'h1);
    tick();
    cmd_valid = 1'b1;
    cmd_msg_id = ID_W'(msg);
    cmd_start_addr = SA_W'(sa);
    cmd_num_words = NW_W'(n);
    tick();
    cmd_valid = 1'b0;
  endtask

  // lat counts negedges after the accept edge until done/error is seen
  task automatic wait_result(input string name, input bit exp_done, input int exp_lat);
    int lat;
    bit seen;
    lat = 0;
    seen = 1'b0;
    while (lat < 200 && !seen) begin
      @(negedge clk);
      lat++;
      if (done || error) seen = 1'b1;
    end
    check({name, "_done"}, {31'b0, done}, {31'b0, exp_done});
    check({name, "_error"}, {31'b0, error}, {31'b0, !exp_done});
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    @(negedge clk);
    check({name, "_pulse_one_cycle"}, {31'b0, done | error}, 32'h0);
    check({name, "_cmd_ready_after"}, {31'b0, cmd_ready}, 32'h1);
  endtask

  task automatic clear_logs();
    obs_addr_q.delete();
    obs_data_q.delete();
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  initial begin
    int d0, e0, c0;
    n_rst = 1'b0;
    cmd_valid = 1'b0;
    cmd_valid3 = 1'b0;
    cmd_msg_id = '0;
    cmd_start_addr = '0;
    cmd_num_words = '0;
    data_valid = 1'b0;
    data_word = '0;
    bus_request_stall = 1'b0;
    err_on_send = 1'b0;
    foreach (slot_reg[i]) slot_reg[i] = '0;
    foreach (cache_mem[i]) cache_mem[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'h1);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_wen", {31'b0, bus_wen}, 32'h0);
    check("rst_bus_ren", {31'b0, bus_ren}, 32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    check("rst_bus_strobe", {28'b0, bus_strobe}, 32'h0);
    check("rst_data_ready", {31'b0, data_ready}, 32'h0);
    check("rst_done_error", {30'b0, done, error}, 32'h0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic load: 0x4<-0x10, 0x2010..0x2018 <- A,B,C, 0x1004<-1
    clear_logs();
    words = '{32'hA, 32'hB, 32'hC};
    model_load(1, 32'h10, 3);
    fork
      stream(-1, 0);
      begin
        issue(1, 32'h10, 3);
        wait_result("basic", 1'b1, 6 + RB);
      end
    join
    check("basic_write_count", 32'(obs_addr_q.size()), 32'd5);
    check("basic_w0_addr", obs_addr_q[0], 32'h4);
    check("basic_w0_data", obs_data_q[0], 32'h10);
    check("basic_w1_addr", obs_addr_q[1], 32'h2010);
    check("basic_w1_data", obs_data_q[1], 32'hA);
    check("basic_w3_addr", obs_addr_q[3], 32'h2018);
    check("basic_w3_data", obs_data_q[3], 32'hC);
    check("basic_w4_addr", obs_addr_q[4], 32'h1004);
    check("basic_w4_data", obs_data_q[4], 32'h1);
    check("basic_model_drained", 32'(exp_addr_q.size()), 32'd0);

    // Stall for 3 cycles during the second word
    clear_logs();
    foreach (cache_mem[i]) cache_mem[i] = '0;
    model_load(1, 32'h10, 3);
    fork
      stream(-1, 0);
      begin
        issue(1, 32'h10, 3);
        fork
          begin
            repeat (2 + RB) tick();
            bus_request_stall = 1'b1;
            repeat (3) tick();
            bus_request_stall = 1'b0;
          end
          wait_result("stall", 1'b1, 9 + RB);
        join
      end
    join
    check("stall_mem4", cache_mem[4], 32'hA);
    check("stall_mem5", cache_mem[5], 32'hB);
    check("stall_mem6", cache_mem[6], 32'hC);
    check("stall_slot1", slot_reg[1], 32'h10);
    check("stall_model_drained", 32'(exp_addr_q.size()), 32'd0);

    // Two-cycle stream gap before the third word
    clear_logs();
    words = '{32'h100, 32'h200, 32'h300, 32'h400};
    model_load(3, 32'h0, 4);
    c0 = consumed;
    fork
      stream(2, 2);
      begin
        issue(3, 32'h0, 4);
        wait_result("gap", 1'b1, 9 + RB);
      end
    join
    check("gap_words_consumed", 32'(consumed - c0), 32'd4);
    check("gap_write_count", 32'(obs_addr_q.size()), 32'd6);
    check("gap_mem3", cache_mem[3], 32'h400);

    // Window boundary accepted: word 126 + 2 words == 128
    clear_logs();
    words = '{32'hDEAD0001, 32'hDEAD0002};
    model_load(0, 32'h1F8, 2);
    fork
      stream(-1, 0);
      begin
        issue(0, 32'h1F8, 2);
        wait_result("edge_accept", 1'b1, 5 + RB);
      end
    join
    check("edge_mem127", cache_mem[127], 32'hDEAD0002);

    // Rejects: window overflow, zero words
    clear_logs();
    issue(0, 32'h1F8, 3);
    wait_result("rej_window", 1'b0, 1);
    issue(2, 32'h0, 0);
    wait_result("rej_zero", 1'b0, 1);
    check("rej_no_writes", 32'(obs_addr_q.size()), 32'd0);

    // Reject out-of-range slot on the three-slot instance
    tick();
    cmd_valid3 = 1'b1;
    cmd_msg_id = 2'd3;
    cmd_start_addr = '0;
    cmd_num_words = 8'd1;
    tick();
    cmd_valid3 = 1'b0;
    @(negedge clk);
    check("rej_id_error", {31'b0, error3}, 32'h1);
    check("rej_id_done", {31'b0, done3}, 32'h0);
    check("rej_id_no_bus", {29'b0, bus_wen3, bus_ren3, data_ready3}, 32'h0);
    check("rej_id_addr", bus_addr3, 32'h0);
    check("rej_id_wdata", bus_wdata3, 32'h0);
    check("rej_id_strobe", {28'b0, bus_strobe3}, 32'h0);
    @(negedge clk);
    check("rej_id_pulse_end", {31'b0, error3}, 32'h0);
    check("rej_id_cmd_ready", {31'b0, cmd_ready3}, 32'h1);

    // Bus error on the send write
    clear_logs();
    words = '{32'h55, 32'h66};
    model_load(2, 32'h20, 2);
    d0 = done_cnt;
    err_on_send = 1'b1;
    fork
      stream(-1, 0);
      begin
        issue(2, 32'h20, 2);
        wait_result("bus_err", 1'b0, 5 + RB);
      end
    join
    err_on_send = 1'b0;
    check("bus_err_no_done", 32'(done_cnt - d0), 32'd0);
    check("bus_err_model_drained", 32'(exp_addr_q.size()), 32'd0);

    // Reset during WRITE_DATA after the first word
    clear_logs();
    words = '{32'h1, 32'h2, 32'h3};
    model_load(1, 32'h40, 3);
    d0 = done_cnt;
    e0 = err_cnt;
    fork
      stream(-1, 0);
      begin
        issue(1, 32'h40, 3);
        repeat (2 + RB) tick();
        @(negedge clk);
        n_rst = 1'b0;
        stream_abort = 1'b1;
        #1;
        check("mid_rst_wen", {31'b0, bus_wen}, 32'h0);
        check("mid_rst_addr", bus_addr, 32'h0);
        check("mid_rst_wdata", bus_wdata, 32'h0);
        check("mid_rst_strobe", {28'b0, bus_strobe}, 32'h0);
        check("mid_rst_data_ready", {31'b0, data_ready}, 32'h0);
        check("mid_rst_pulses", {30'b0, done, error}, 32'h0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
      end
    join
    stream_abort = 1'b0;
    clear_logs();
    repeat (5) @(negedge clk);
    check("mid_rst_cmd_ready", {31'b0, cmd_ready}, 32'h1);
    check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
    check("mid_rst_no_error", 32'(err_cnt - e0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
    $fatal(1);
  end

endmodule
